// File: rtl/bm_product_accumulate_pkg.sv
// Shared definitions for the product-accumulate stage: the state encodings and
// default widths as `define values (the same form the multiplier benches use),
// plus a package that wraps them in typed form.
`ifndef BM_PRODUCT_ACCUMULATE_DEFS
`define BM_PRODUCT_ACCUMULATE_DEFS
`define BM_ST_IDLE   2'd0
`define BM_ST_ACCUM  2'd1
`define BM_ST_HOLD   2'd2
`define BM_BITS      16
`define BM_ACC_BITS  18
`define BM_COUNT     4
`define BM_CNT_BITS  8
`endif

package bm_product_accumulate_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = `BM_ST_IDLE,
    ST_ACCUM = `BM_ST_ACCUM,
    ST_HOLD  = `BM_ST_HOLD
  } state_t;

  localparam int DEF_BITS     = `BM_BITS;
  localparam int DEF_ACC_BITS = `BM_ACC_BITS;
  localparam int DEF_COUNT    = `BM_COUNT;
  localparam int DEF_CNT_BITS = `BM_CNT_BITS;

endpackage

// File: rtl/bm_product_accumulate_sat_add.sv
// Combinational W-bit unsigned adder that clamps to all-ones on carry out and
// reports that the clamp happened.
module bm_sat_add #(
  parameter int W = 18
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         sat
);

  logic [W:0] full;

  // One extra bit of width exposes the carry that decides saturation.
  always_comb begin
    full = {1'b0, a} + {1'b0, b};
    sat  = full[W];
    sum  = full[W] ? {W{1'b1}} : full[W-1:0];
  end

endmodule

// File: rtl/bm_product_accumulate.sv
// Accumulates COUNT unsigned products into one saturating sum per block and
// presents each sum on a valid/ready output. Products offered while a sum is
// held are back-pressured, never dropped.
module bm_product_accumulate
  import bm_product_accumulate_pkg::*;
#(
  parameter int BITS     = DEF_BITS,
  parameter int ACC_BITS = DEF_ACC_BITS,
  parameter int COUNT    = DEF_COUNT,
  parameter int CNT_BITS = DEF_CNT_BITS
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [BITS-1:0]     prod_in,
  input  logic                prod_valid,
  output logic                prod_ready,
  input  logic                clear,
  output logic [ACC_BITS-1:0] sum_out,
  output logic                sum_overflow,
  output logic [CNT_BITS-1:0] sum_count,
  output logic                sum_valid,
  input  logic                sum_ready
);

  localparam logic [CNT_BITS-1:0] COUNT_C = CNT_BITS'(COUNT);
  localparam logic [CNT_BITS-1:0] ONE_C   = CNT_BITS'(1);

  state_t              state;
  logic [ACC_BITS-1:0] acc;
  logic [CNT_BITS-1:0] cnt;
  logic                flag;

  logic [ACC_BITS-1:0] prod_ext;
  logic [ACC_BITS-1:0] add_sum;
  logic                add_sat;
  logic [CNT_BITS-1:0] cnt_next;
  logic                accept;
  logic                flag_next;

  // Ready depends only on state and clear so it never loops back on prod_valid.
  assign prod_ready = ((state == ST_IDLE) || (state == ST_ACCUM)) && !clear;
  assign accept     = prod_valid && prod_ready;
  assign prod_ext   = ACC_BITS'(prod_in);
  assign cnt_next   = cnt + ONE_C;
  assign flag_next  = flag | add_sat;

  bm_sat_add #(.W(ACC_BITS)) u_sat_add (
    .a   (acc),
    .b   (prod_ext),
    .sum (add_sum),
    .sat (add_sat)
  );

  // Block FSM: reset, then clear, then accumulate / hold / hand off.
  // NOTE: reset is sampled only on the clock edge, so it sits inside the
  // posedge-only sensitivity; all state uses <= so every register samples the
  // pre-edge values of its neighbours.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      acc          <= '0;
      cnt          <= '0;
      flag         <= 1'b0;
      sum_out      <= '0;
      sum_overflow <= 1'b0;
      sum_count    <= '0;
      sum_valid    <= 1'b0;
    end else if (clear) begin
      state     <= ST_IDLE;
      acc       <= '0;
      cnt       <= '0;
      flag      <= 1'b0;
      sum_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            acc  <= prod_ext;
            cnt  <= ONE_C;
            flag <= 1'b0;
            if (COUNT == 1) begin
              state        <= ST_HOLD;
              sum_out      <= prod_ext;
              sum_overflow <= 1'b0;
              sum_count    <= ONE_C;
              sum_valid    <= 1'b1;
            end else begin
              state <= ST_ACCUM;
            end
          end
        end
        ST_ACCUM: begin
          if (accept) begin
            acc  <= add_sum;
            flag <= flag_next;
            cnt  <= cnt_next;
            if (cnt_next == COUNT_C) begin
              state        <= ST_HOLD;
              sum_out      <= add_sum;
              sum_overflow <= flag_next;
              sum_count    <= cnt_next;
              sum_valid    <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (sum_valid && sum_ready) begin
            state     <= ST_IDLE;
            sum_valid <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
          acc   <= '0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bm_product_accumulate.sv
// Self-checking bench for bm_product_accumulate (ACC_BITS=17 so four maximal
// products saturate). Expected sums are queued when a block is driven and
// compared when the DUT hands the sum off.
module tb_bm_product_accumulate;

  localparam int BITS = 16;
  localparam int ACC  = 17;
  localparam int CNTB = 8;

  logic            clock = 1'b0;
  logic            reset_n;
  logic [BITS-1:0] prod_in;
  logic            prod_valid;
  logic            prod_ready;
  logic            clear;
  logic [ACC-1:0]  sum_out;
  logic            sum_overflow;
  logic [CNTB-1:0] sum_count;
  logic            sum_valid;
  logic            sum_ready;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [ACC-1:0] sum;
    logic           ovf;
  } exp_t;

  typedef struct {
    logic [BITS-1:0] p   [4];
    int              gap [4];
    logic [ACC-1:0]  sum;
    logic            ovf;
  } vec_t;

  exp_t sb[$];
  vec_t vecs [7];

  always #5 clock = ~clock;

  bm_product_accumulate #(
    .BITS(BITS), .ACC_BITS(ACC), .COUNT(4), .CNT_BITS(CNTB)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .prod_in      (prod_in),
    .prod_valid   (prod_valid),
    .prod_ready   (prod_ready),
    .clear        (clear),
    .sum_out      (sum_out),
    .sum_overflow (sum_overflow),
    .sum_count    (sum_count),
    .sum_valid    (sum_valid),
    .sum_ready    (sum_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Offer one product and return just after the edge that accepts it.
  task automatic send(input logic [BITS-1:0] v);
    bit done = 1'b0;
    prod_in    = v;
    prod_valid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clock);
      if (prod_ready) done = 1'b1;
      @(posedge clock);
      #1;
    end
    prod_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: product %0h never accepted", v);
    end
  endtask

  task automatic push(input logic [ACC-1:0] s, input logic o);
    exp_t e;
    e.sum = s;
    e.ovf = o;
    sb.push_back(e);
  endtask

  task automatic send_block(input vec_t v);
    push(v.sum, v.ovf);
    for (int k = 0; k < 4; k++) begin
      idle(v.gap[k]);
      send(v.p[k]);
    end
  endtask

  // Scoreboard: every handshake must match the oldest queued expectation.
  always @(negedge clock) begin
    exp_t e;
    if (reset_n && sum_valid && sum_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_sum: got %0h with nothing expected", sum_out);
      end else begin
        e = sb.pop_front();
        check("sum_out", 32'(sum_out), 32'(e.sum));
        check("sum_overflow", 32'(sum_overflow), 32'(e.ovf));
        check("sum_count", 32'(sum_count), 32'd4);
      end
    end
  end

  initial begin
    vecs[0] = '{p: '{16'd3, 16'd5, 16'd7, 16'd9}, gap: '{0, 0, 0, 0}, sum: 17'd24, ovf: 1'b0};
    vecs[1] = '{p: '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, gap: '{0, 0, 0, 0}, sum: 17'h1FFFF, ovf: 1'b1};
    vecs[2] = '{p: '{16'd1, 16'd1, 16'd1, 16'd1}, gap: '{0, 0, 0, 0}, sum: 17'd4, ovf: 1'b0};
    vecs[3] = '{p: '{16'hFFFF, 16'hFFFF, 16'd1, 16'd1}, gap: '{0, 1, 0, 0}, sum: 17'h1FFFF, ovf: 1'b1};
    vecs[4] = '{p: '{16'hFFFF, 16'hFFFF, 16'd1, 16'd0}, gap: '{0, 0, 0, 0}, sum: 17'h1FFFF, ovf: 1'b0};
    vecs[5] = '{p: '{16'd2, 16'd4, 16'd6, 16'd8}, gap: '{0, 2, 1, 0}, sum: 17'd20, ovf: 1'b0};
    vecs[6] = '{p: '{16'd0, 16'd0, 16'd0, 16'd0}, gap: '{1, 0, 3, 0}, sum: 17'd0, ovf: 1'b0};

    reset_n    = 1'b0;
    prod_in    = '0;
    prod_valid = 1'b0;
    clear      = 1'b0;
    sum_ready  = 1'b1;
    idle(2);
    check("reset_sum_valid", 32'(sum_valid), 32'd0);
    check("reset_sum_out", 32'(sum_out), 32'd0);
    check("reset_sum_overflow", 32'(sum_overflow), 32'd0);
    check("reset_sum_count", 32'(sum_count), 32'd0);
    reset_n = 1'b1;
    idle(1);
    check("reset_prod_ready", 32'(prod_ready), 32'd1);

    // Basic block with one-cycle latency and ready returning after handshake.
    push(17'd24, 1'b0);
    send(16'd3);
    send(16'd5);
    send(16'd7);
    send(16'd9);
    check("latency_sum_valid", 32'(sum_valid), 32'd1);
    check("hold_prod_ready", 32'(prod_ready), 32'd0);
    idle(1);
    check("post_hs_sum_valid", 32'(sum_valid), 32'd0);
    check("post_hs_prod_ready", 32'(prod_ready), 32'd1);

    // Table of blocks covering saturation, stickiness, exact max and gaps.
    for (int i = 0; i < 7; i++) begin
      send_block(vecs[i]);
      idle(1);
    end

    // Back-pressure: sum held, 99 stalled, then first product of next block.
    sum_ready = 1'b0;
    push(17'd100, 1'b0);
    send(16'd10);
    send(16'd20);
    send(16'd30);
    send(16'd40);
    prod_in    = 16'd99;
    prod_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_sum_valid", 32'(sum_valid), 32'd1);
      check("bp_sum_out", 32'(sum_out), 32'd100);
      check("bp_prod_ready", 32'(prod_ready), 32'd0);
      idle(1);
    end
    push(17'd105, 1'b0);
    sum_ready = 1'b1;
    send(16'd99);
    send(16'd1);
    send(16'd2);
    send(16'd3);
    idle(1);

    // Clear mid-block discards the partial sum and the concurrent product.
    send(16'd7);
    send(16'd7);
    prod_in    = 16'd50;
    prod_valid = 1'b1;
    clear      = 1'b1;
    @(negedge clock);
    check("clear_prod_ready", 32'(prod_ready), 32'd0);
    @(posedge clock);
    #1;
    clear      = 1'b0;
    prod_valid = 1'b0;
    check("clear_sum_valid", 32'(sum_valid), 32'd0);
    push(17'd10, 1'b0);
    send(16'd1);
    send(16'd2);
    send(16'd3);
    send(16'd4);
    idle(2);

    // Reset while a saturated sum is held; only the edge takes effect.
    sum_ready = 1'b0;
    send(16'hFFFF);
    send(16'hFFFF);
    send(16'hFFFF);
    send(16'hFFFF);
    check("rst_hold_valid", 32'(sum_valid), 32'd1);
    check("rst_hold_ovf", 32'(sum_overflow), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("rst_async_valid", 32'(sum_valid), 32'd1);
    check("rst_async_sum", 32'(sum_out), 32'h1FFFF);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    check("rst_sum_valid", 32'(sum_valid), 32'd0);
    check("rst_sum_out", 32'(sum_out), 32'd0);
    check("rst_sum_overflow", 32'(sum_overflow), 32'd0);
    check("rst_sum_count", 32'(sum_count), 32'd0);
    check("rst_prod_ready", 32'(prod_ready), 32'd1);
    sum_ready = 1'b1;
    idle(3);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bm_product_accumulate.md
Name: bm_product_accumulate

Overview:
Downstream consumer of the multiplier benchmark stage. It takes a stream of unsigned products, accumulates COUNT of them into one saturating sum per block, and presents each sum on a valid/ready output. The accumulate path exercises synthesis of a registered adder, counter and FSM alongside the multiplier benches.

Parameters:
BITS, 16, width of each incoming product (matches the multiplier's 2x-operand output width)
ACC_BITS, 18, accumulator and sum width; must be >= BITS
COUNT, 4, products per block; legal range 1..255
CNT_BITS, 8, width of the product counter

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  synchronous active-low reset
prod_in  input  BITS  unsigned product from the multiplier stage
prod_valid  input  1  prod_in is valid this cycle
prod_ready  output  1  block accepts prod_in this cycle
clear  input  1  synchronous abort of the current block
sum_out  output  ACC_BITS  accumulated block sum
sum_overflow  output  1  sticky per block: saturation occurred during this block
sum_count  output  CNT_BITS  number of products in the presented sum; equals COUNT
sum_valid  output  1  sum_out, sum_overflow and sum_count are valid
sum_ready  input  1  downstream takes the sum

Behaviour:
- Reset (clock edge with reset_n=0): state=IDLE, acc=0, cnt=0, sum_out=0, sum_overflow=0, sum_count=0, sum_valid=0. prod_ready=1 from the next cycle.
- Priority at each edge: reset_n=0, then clear, then normal operation.
- clear=1: state=IDLE, acc=0, cnt=0, sum_valid=0, overflow flag=0. A product offered in the same cycle is discarded. A held sum is dropped.
- Accept condition: prod_valid & prod_ready. prod_ready = (state==IDLE or state==ACCUM) and clear=0, so prod_ready is combinational from state and clear only.
- IDLE, on accept:
  - acc = zero-extended prod_in, cnt=1, flag=0.
  - If COUNT==1, go to HOLD; otherwise go to ACCUM.
- ACCUM, on accept:
  - Compute acc + prod_in at ACC_BITS+1 width.
  - If the carry is set, acc = all-ones and flag=1 (saturation). Otherwise acc = the sum.
  - cnt = cnt+1. When the new cnt equals COUNT, go to HOLD.
  - No accept: all registers hold.
- Entering HOLD: sum_out=acc, sum_overflow=flag, sum_count=cnt, sum_valid=1. Latency is one cycle, i.e. sum_valid is high in the cycle after the COUNT-th accept.
- HOLD:
  - prod_ready=0. Outputs stay stable while sum_ready=0.
  - On sum_valid & sum_ready: sum_valid=0, acc=0, cnt=0, go to IDLE. The outputs sum_out, sum_overflow and sum_count keep their last values.
  - Products offered during HOLD are back-pressured, never lost. The earliest next accept is the cycle after the handshake.
- Once saturated, acc stays at all-ones for the rest of the block. The flag clears only on the first accept of a new block, or on clear or reset.
- Reset or clear mid-block abandons any partial sum with no output.
- The counter never wraps, because COUNT <= 2^CNT_BITS-1.
- FSM states: IDLE=2'd0, ACCUM=2'd1, HOLD=2'd2. Encoding 2'd3 is unreachable; if entered, go to IDLE with acc cleared.

Decomposition:
- A shared include header holds the state encodings and default widths as `define values. This matches how the multiplier benches take BITS/B2TS.
- One sub-module: bm_sat_add (parameter W). It is a combinational W-bit unsigned adder with carry out, returning the saturated result and a sat flag. It is instantiated once for the accumulate path.
- Everything else stays in bm_product_accumulate.

Test Plan:
- Basic block (COUNT=4): products 3,5,7,9 on consecutive cycles, sum_ready=1 -> sum_valid one cycle after the 4th accept with sum_out=24, sum_overflow=0, sum_count=4; prod_ready=1 again the cycle after the handshake.
- Saturation (ACC_BITS=17 override): four products of 16'hFFFF -> sum_out=17'h1FFFF, sum_overflow=1. A following block of 1,1,1,1 -> sum_out=4, sum_overflow=0.
- Back-pressure: complete a block of 10,20,30,40 with sum_ready=0 for 5 cycles and prod_valid=1 with value 99 throughout -> sum_out=100 stable, prod_ready=0 during HOLD. 99 is accepted only after the handshake and becomes the first product of the next block.
- Gapped input: products 2,_,_,4,_,6,8, where _ means prod_valid=0 -> sum_out=20, with no extra counts from idle cycles.
- Clear mid-block: accept 7,7, assert clear with prod_valid=1 and prod_in=50, then send 1,2,3,4 -> 50 discarded, single output sum_out=10.
- Reset mid-HOLD: with sum_valid=1, pull reset_n low for one edge -> sum_valid=0, sum_out=0, sum_overflow=0, sum_count=0, state IDLE. Asynchronous assertion between edges must have no effect until the next edge.
